// File: rtl/msg_ctrl_pkg.sv
// rtl/msg_ctrl_pkg.sv - shared state, message-id types and message map for msg_stream_ctrl
package msg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    GAP   = 3'd4
  } state_t;

  typedef enum logic {
    MSG_0 = 1'b0,
    MSG_1 = 1'b1
  } msg_id_t;

  localparam int MSG0_BASE_C = 0;
  localparam int MSG0_LAST_C = 58;
  localparam int MSG1_BASE_C = 59;
  localparam int MSG1_LAST_C = 135;

endpackage

// File: rtl/msg_pace_timer.sv
// rtl/msg_pace_timer.sv - loadable down-counter timing the inter-character gap
module msg_pace_timer #(
  parameter int PACE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [PACE_W-1:0] load_val,
  input  logic              run,
  output logic              expire
);

  logic [PACE_W-1:0] count;

  // Load on request, otherwise count down while running; parks at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && (count != '0)) begin
      count <= count - PACE_W'(1);
    end
  end

  // Expiry on the last gap cycle, so a load of N gives exactly N run cycles.
  assign expire = run && (count == PACE_W'(1));

endmodule

// File: rtl/msg_stream_ctrl.sv
// rtl/msg_stream_ctrl.sv - sequences stored ROM messages onto a valid/ready character stream
module msg_stream_ctrl
  import msg_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int PACE_W    = 16,
  parameter int MSG0_BASE = MSG0_BASE_C,
  parameter int MSG0_LAST = MSG0_LAST_C,
  parameter int MSG1_BASE = MSG1_BASE_C,
  parameter int MSG1_LAST = MSG1_LAST_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              msg_sel,
  input  logic              loop_en,
  input  logic              abort,
  input  logic [PACE_W-1:0] pace_div,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_d, base_q, base_d, last_q, last_d;
  logic [PACE_W-1:0] pace_q, pace_d;
  logic [7:0]        data_d;
  logic              valid_d, done_d;
  logic              hs, cont;
  logic              gap_load, gap_run, gap_expire;
  msg_id_t           sel_id;

  assign busy   = (state != IDLE);
  assign hs     = char_valid && char_ready;
  assign sel_id = msg_id_t'(msg_sel);

  msg_pace_timer #(
    .PACE_W(PACE_W)
  ) u_pace (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gap_load),
    .load_val(pace_q),
    .run     (gap_run),
    .expire  (gap_expire)
  );

  // Next-state and next-datapath decode; abort overrides every busy state.
  always_comb begin
    state_d  = state;
    addr_d   = rom_addr;
    data_d   = char_data;
    valid_d  = char_valid;
    done_d   = 1'b0;
    base_d   = base_q;
    last_d   = last_q;
    pace_d   = pace_q;
    cont     = 1'b0;
    gap_load = 1'b0;
    gap_run  = 1'b0;
    if (abort && (state != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            base_d  = (sel_id == MSG_1) ? ADDR_W'(MSG1_BASE) : ADDR_W'(MSG0_BASE);
            last_d  = (sel_id == MSG_1) ? ADDR_W'(MSG1_LAST) : ADDR_W'(MSG0_LAST);
            pace_d  = pace_div;
            addr_d  = base_d;
            state_d = FETCH;
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          data_d  = rom_data;
          valid_d = 1'b1;
          state_d = SEND;
        end
        SEND: begin
          if (hs) begin
            valid_d = 1'b0;
            if (rom_addr != last_q) begin
              addr_d = rom_addr + ADDR_W'(1);
              cont   = 1'b1;
            end else if (loop_en) begin
              addr_d = base_q;
              cont   = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
            if (cont) begin
              if (pace_q == '0) begin
                state_d = FETCH;
              end else begin
                gap_load = 1'b1;
                state_d  = GAP;
              end
            end
          end
        end
        GAP: begin
          gap_run = 1'b1;
          if (gap_expire) state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      char_data  <= '0;
      char_valid <= 1'b0;
      done       <= 1'b0;
      base_q     <= ADDR_W'(MSG0_BASE);
      last_q     <= ADDR_W'(MSG0_LAST);
      pace_q     <= '0;
    end else begin
      state      <= state_d;
      rom_addr   <= addr_d;
      char_data  <= data_d;
      char_valid <= valid_d;
      done       <= done_d;
      base_q     <= base_d;
      last_q     <= last_d;
      pace_q     <= pace_d;
    end
  end

endmodule

// File: doc/msg_stream_ctrl.md
Name: msg_stream_ctrl

Overview:
Sequences playback of stored ASCII messages from a character ROM to a downstream character sink, such as the 8-bit output pins or a UART transmitter. On a start request it latches a message selection and walks the ROM address range for that message. Each character is presented on a valid/ready handshake, with an optional programmable inter-character gap and optional looping. The block sits between the top-level pin wrapper and the message ROM, and replaces free-running counter addressing.

Parameters:
ADDR_W, 8, ROM address width.
PACE_W, 16, width of the inter-character gap count.
MSG0_BASE, 0, first ROM address of message 0.
MSG0_LAST, 58, last ROM address of message 0 (59 characters).
MSG1_BASE, 59, first ROM address of message 1.
MSG1_LAST, 135, last ROM address of message 1 (77 characters).

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous reset, active low.
start  in  1  begin playback; sampled only in IDLE.
msg_sel  in  1  message select; 0 = message 0, 1 = message 1; latched on accepted start.
loop_en  in  1  restart at base after the last character; sampled live at each wrap point.
abort  in  1  terminate playback; highest priority after reset.
pace_div  in  PACE_W  gap in cycles between characters; latched on accepted start.
rom_addr  out  ADDR_W  registered ROM address.
rom_data  in  8  ROM read data; valid one cycle after rom_addr.
char_data  out  8  current character, registered.
char_valid  out  1  char_data valid.
char_ready  in  1  sink accepts char_data.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a non-looping message completes.

Behaviour:
- Clock and reset: single clock clk. Synchronous active-low rst_n, sampled on the rising edge of clk.
- Reset values: state=IDLE, rom_addr=0, char_data=0, char_valid=0, busy=0, done=0, gap counter=0, latched base/last=MSG0.
- FSM states: IDLE, FETCH, WAIT, SEND, GAP.
- IDLE:
  - start=1 → latch msg_sel and pace_div; set base/last; rom_addr<=base; go to FETCH.
  - start=0 → remain in IDLE.
- FETCH: one cycle, lets the ROM register the address; go to WAIT.
- WAIT: char_data<=rom_data; char_valid<=1; go to SEND.
- Start latency: start sampled at edge k → char_valid=1 after edge k+2.
- SEND:
  - Hold char_valid and char_data stable until char_valid&&char_ready at an edge.
  - On that handshake edge, char_valid<=0.
  - If rom_addr≠last: rom_addr<=rom_addr+1.
  - If rom_addr==last and loop_en=1: rom_addr<=base.
  - If rom_addr==last and loop_en=0: done<=1 for one cycle; go to IDLE.
  - If continuing and latched pace=0: go directly to FETCH.
  - If continuing and latched pace>0: go to GAP with counter<=pace.
- GAP: decrement counter each cycle; on the cycle the counter equals 1, go to FETCH. GAP therefore lasts exactly pace cycles.
- Throughput: with ready held high and pace=0, one character every 3 cycles.
- abort=1 in any non-IDLE state: next edge goes to IDLE with char_valid<=0; no done pulse; rom_addr holds its value.
- abort together with start in IDLE: abort wins; remain in IDLE.
- start while busy: ignored; the latched msg_sel and pace do not change.
- Reset mid-playback: all registers return to their reset values on the next edge. A character being presented is dropped.
- Address arithmetic: modulo 2^ADDR_W. Never exceeds the latched last address in normal operation.

Decomposition:
- Shared package msg_ctrl_pkg:
  - state enum {IDLE, FETCH, WAIT, SEND, GAP};
  - MSG base/last constants;
  - message-id type.
- One sub-module, msg_pace_timer:
  - loadable down-counter, PACE_W bits;
  - ports: clk, rst_n, load, load_val, run, expire.
  - The FSM instantiates it for GAP.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0, busy=0; no FETCH on release until start is sampled in IDLE.
- Message 0, ready=1, pace=0, loop_en=0:
  - 59 handshakes at 3-cycle spacing;
  - first char 0xA1 (addr 0), char 10 is 0x20, last char 0x3B (addr 58);
  - exactly one done pulse, then busy=0.
- Backpressure: message 1, ready held low for 5 cycles on the 3rd character → char_valid stays 1 and char_data stays 0x72 unchanged; rom_addr does not advance until the handshake.
- Pacing: pace_div=4, ready=1 → exactly 4 GAP cycles between each handshake and the next FETCH; handshake spacing is 7 cycles.
- Loop: message 1, loop_en=1 → after addr 135 (0x64), the next character is from addr 59 (0x50); no done pulse. Then clear loop_en → one full pass completes with done.
- Abort and stray start: abort at the 10th character of message 0 → char_valid=0 and busy=0 after 1 edge, no done. Start pulsed mid-playback → ignored; msg_sel change has no effect until IDLE.
